// File: rtl/counter_pkg.sv
// Shared op codes and FSM state encodings for the counter command arbiter.
package counter_pkg;

   // Command op codes as carried on the 2-bit per-requester op field
   typedef enum logic [1:0] {
      OP_UP    = 2'b00,
      OP_DOWN  = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   // Command sequencer states: grant, strobe the datapath, report
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request strictly after
// the pointer, wrapping cyclically. The pointer register lives in the caller.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_gnt_idx
);

   int   w_idx;
   logic w_found;

   // Scan from pointer+1 around to the pointer itself; the first hit wins
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NREQ;
         if (i_en && !w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_gnt[w_idx]   = 1'b1;
            o_gnt_idx      = IW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shares one up/down counter datapath between NREQ requesters. Each granted
// command takes exactly three cycles: grant (IDLE), strobe (EXEC), report (RESP).
module counter_cmd_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int WRAP  = 1,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [2*NREQ-1:0]       i_req_op,
   input  logic [WIDTH*NREQ-1:0]   i_req_data,
   output logic [NREQ-1:0]         o_req_ready,
   input  logic                    i_hold,
   input  logic [WIDTH-1:0]        i_cnt_q,
   output logic                    o_cnt_inc,
   output logic                    o_cnt_dec,
   output logic                    o_cnt_load,
   output logic [WIDTH-1:0]        o_cnt_ld_val,
   output logic                    o_rsp_valid,
   output logic [IW-1:0]           o_rsp_id,
   output logic [WIDTH-1:0]        o_rsp_count,
   output logic                    o_rsp_sat
);

   import counter_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_id;
   op_t              r_op;
   logic [WIDTH-1:0] r_data;
   logic             r_sat;

   logic             w_arb_en;
   logic [NREQ-1:0]  w_gnt;
   logic [IW-1:0]    w_gnt_idx;
   logic             w_grant;
   logic [1:0]       w_sel_op;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_sat_now;

   // Grants only from IDLE, never while held, and never while reset is asserted
   assign w_arb_en = (r_state == ST_IDLE) && !i_hold && !rst_n;
   assign w_grant  = |w_gnt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req     (i_req_valid),
      .i_ptr     (r_ptr),
      .i_en      (w_arb_en),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   // Pick out the granted requester's op and load value from the packed buses
   always_comb begin
      w_sel_op   = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_op   = i_req_op[2*i +: 2];
            w_sel_data = i_req_data[WIDTH*i +: WIDTH];
         end
      end
   end

   // Saturating mode suppresses UP at all-ones and DOWN at zero
   always_comb begin
      w_sat_now = 1'b0;
      if (WRAP == 0) begin
         if (r_op == OP_UP && i_cnt_q == {WIDTH{1'b1}}) w_sat_now = 1'b1;
         if (r_op == OP_DOWN && i_cnt_q == '0)          w_sat_now = 1'b1;
      end
   end

   // State register; reset drops any in-flight command back to IDLE
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Command latches: capture op/data/id on grant, capture saturation in EXEC
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_ptr  <= IW'(NREQ-1);
         r_id   <= '0;
         r_op   <= OP_UP;
         r_data <= '0;
         r_sat  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_grant) begin
            r_ptr  <= w_gnt_idx;
            r_id   <= w_gnt_idx;
            r_op   <= op_t'(w_sel_op);
            r_data <= w_sel_data;
            r_sat  <= 1'b0;
         end
         if (r_state == ST_EXEC) r_sat <= w_sat_now;
      end
   end

   // Next-state and output decode; every output idles at zero outside its state
   always_comb begin
      w_state_nxt  = r_state;
      o_req_ready  = '0;
      o_cnt_inc    = 1'b0;
      o_cnt_dec    = 1'b0;
      o_cnt_load   = 1'b0;
      o_cnt_ld_val = '0;
      o_rsp_valid  = 1'b0;
      o_rsp_id     = '0;
      o_rsp_count  = '0;
      o_rsp_sat    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_req_ready = w_gnt;
            if (w_grant) w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_state_nxt = ST_RESP;
            if (!w_sat_now) begin
               case (r_op)
                  OP_UP:    o_cnt_inc = 1'b1;
                  OP_DOWN:  o_cnt_dec = 1'b1;
                  OP_LOAD:  begin
                     o_cnt_load   = 1'b1;
                     o_cnt_ld_val = r_data;
                  end
                  OP_CLEAR: o_cnt_load = 1'b1;
                  default:  o_cnt_load = 1'b0;
               endcase
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
            o_rsp_valid = 1'b1;
            o_rsp_id    = r_id;
            o_rsp_count = i_cnt_q;
            o_rsp_sat   = r_sat;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Testbench for counter_cmd_arbiter: a wrapping and a saturating instance share
// the same requesters; each has its own counter register in the bench.
module tb_counter_cmd_arbiter;
   import counter_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IW    = $clog2(NREQ);
   localparam int MODV  = 2**WIDTH;
   localparam int MAXV  = 2**WIDTH - 1;

   typedef struct packed { logic [1:0] op; logic [WIDTH-1:0] data; } cmd_t;
   typedef struct { int id; int cntA; int cntB; int satB; } exp_t;
   typedef struct { int cyc; int id; int count; int sat; } rsp_t;
   typedef struct { int cyc; int kind; int val; } stb_t;
   typedef struct { int cyc; int id; } gnt_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       reqValid;
   logic [2*NREQ-1:0]     reqOp;
   logic [WIDTH*NREQ-1:0] reqData;
   logic                  hold;
   logic [NREQ-1:0]       readyA, readyB;
   logic [WIDTH-1:0]      cntA, cntB;
   logic                  incA, decA, loadA, incB, decB, loadB;
   logic [WIDTH-1:0]      ldValA, ldValB;
   logic                  rspValidA, rspValidB;
   logic [IW-1:0]         rspIdA, rspIdB;
   logic [WIDTH-1:0]      rspCountA, rspCountB;
   logic                  rspSatA, rspSatB;
   logic                  presetEn;
   logic [WIDTH-1:0]      presetVal;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int badReady = 0;
   int badStrobe = 0;
   int badRsp = 0;

   gnt_t gq[$];
   stb_t sqA[$];
   stb_t sqB[$];
   rsp_t rqA[$];
   rsp_t rqB[$];
   cmd_t cq[NREQ][$];
   exp_t eq[$];
   int   mdlLast, mdlCntA, mdlCntB;

   // Free-running clock
   always #5 clk = ~clk;

   counter_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WRAP(1)) dutWrap (
      .clk(clk), .rst_n(rst_n), .i_req_valid(reqValid), .i_req_op(reqOp),
      .i_req_data(reqData), .o_req_ready(readyA), .i_hold(hold), .i_cnt_q(cntA),
      .o_cnt_inc(incA), .o_cnt_dec(decA), .o_cnt_load(loadA), .o_cnt_ld_val(ldValA),
      .o_rsp_valid(rspValidA), .o_rsp_id(rspIdA), .o_rsp_count(rspCountA), .o_rsp_sat(rspSatA)
   );

   counter_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WRAP(0)) dutSat (
      .clk(clk), .rst_n(rst_n), .i_req_valid(reqValid), .i_req_op(reqOp),
      .i_req_data(reqData), .o_req_ready(readyB), .i_hold(hold), .i_cnt_q(cntB),
      .o_cnt_inc(incB), .o_cnt_dec(decB), .o_cnt_load(loadB), .o_cnt_ld_val(ldValB),
      .o_rsp_valid(rspValidB), .o_rsp_id(rspIdB), .o_rsp_count(rspCountB), .o_rsp_sat(rspSatB)
   );

   // Counter datapaths driven by each instance's strobes (wrap is natural 8-bit)
   always @(posedge clk) begin
      if (presetEn) begin
         cntA <= presetVal;
         cntB <= presetVal;
      end else begin
         if (incA)       cntA <= cntA + 1'b1;
         else if (decA)  cntA <= cntA - 1'b1;
         else if (loadA) cntA <= ldValA;
         if (incB)       cntB <= cntB + 1'b1;
         else if (decB)  cntB <= cntB - 1'b1;
         else if (loadB) cntB <= ldValB;
      end
   end

   function automatic int kindOf(logic inc, logic dec);
      return inc ? 0 : (dec ? 1 : 2);
   endfunction

   // Passive monitor on the falling edge: logs grants, strobes and responses
   always @(negedge clk) begin : monitor
      gnt_t g;
      stb_t s;
      rsp_t r;
      cyc = cyc + 1;
      if (|readyA) begin
         g.cyc = cyc;
         g.id  = -1;
         for (int i = 0; i < NREQ; i++) if (readyA[i]) g.id = i;
         gq.push_back(g);
         if ($countones(readyA) != 1 || (readyA & ~reqValid) != '0) badReady = badReady + 1;
      end
      if (readyB !== readyA) badReady = badReady + 1;
      if (incA | decA | loadA) begin
         s.cyc = cyc; s.kind = kindOf(incA, decA); s.val = int'(ldValA);
         sqA.push_back(s);
      end
      if (incB | decB | loadB) begin
         s.cyc = cyc; s.kind = kindOf(incB, decB); s.val = int'(ldValB);
         sqB.push_back(s);
      end
      if ($countones({incA, decA, loadA}) > 1 || $countones({incB, decB, loadB}) > 1) badStrobe = badStrobe + 1;
      if ((!loadA && ldValA != '0) || (!loadB && ldValB != '0)) badStrobe = badStrobe + 1;
      if (rspValidA) begin
         r.cyc = cyc; r.id = int'(rspIdA); r.count = int'(rspCountA); r.sat = int'(rspSatA);
         rqA.push_back(r);
      end else if (rspIdA != '0 || rspCountA != '0 || rspSatA) badRsp = badRsp + 1;
      if (rspSatA) badRsp = badRsp + 1;
      if (rspValidB) begin
         r.cyc = cyc; r.id = int'(rspIdB); r.count = int'(rspCountB); r.sat = int'(rspSatB);
         rqB.push_back(r);
      end else if (rspIdB != '0 || rspCountB != '0 || rspSatB) badRsp = badRsp + 1;
   end

   function automatic cmd_t mkCmd(logic [1:0] op, logic [WIDTH-1:0] d);
      cmd_t c;
      c.op = op;
      c.data = d;
      return c;
   endfunction

   function automatic void clearLogs();
      gq.delete(); sqA.delete(); sqB.delete(); rqA.delete(); rqB.delete(); eq.delete();
   endfunction

   // Reference model: serve pending command lists in round-robin order and
   // compute each resulting count for a wrapping and a saturating counter
   function automatic void modelPlan();
      cmd_t tq[NREQ][$];
      cmd_t c;
      exp_t e;
      int   id;
      int   cand;
      for (int i = 0; i < NREQ; i++) tq[i] = cq[i];
      while (1) begin
         id = -1;
         for (int k = 1; k <= NREQ; k++) begin
            cand = (mdlLast + k) % NREQ;
            if (id < 0 && tq[cand].size() > 0) id = cand;
         end
         if (id < 0) break;
         c = tq[id].pop_front();
         e.id = id;
         e.satB = 0;
         case (c.op)
            2'b00: begin
               mdlCntA = (mdlCntA + 1) % MODV;
               if (mdlCntB == MAXV) e.satB = 1; else mdlCntB = mdlCntB + 1;
            end
            2'b01: begin
               mdlCntA = (mdlCntA + MODV - 1) % MODV;
               if (mdlCntB == 0) e.satB = 1; else mdlCntB = mdlCntB - 1;
            end
            2'b10: begin
               mdlCntA = int'(c.data);
               mdlCntB = int'(c.data);
            end
            default: begin
               mdlCntA = 0;
               mdlCntB = 0;
            end
         endcase
         e.cntA = mdlCntA;
         e.cntB = mdlCntB;
         eq.push_back(e);
         mdlLast = id;
      end
   endfunction

   // Present every queued command, holding each until its ready pulse
   task automatic driveAll(input int budget, output int timedOut);
      logic [NREQ-1:0] rdy;
      int n;
      int any;
      n = 0;
      timedOut = 0;
      while (1) begin
         any = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (cq[i].size() > 0) begin
               reqValid[i] = 1'b1;
               reqOp[2*i +: 2] = cq[i][0].op;
               reqData[WIDTH*i +: WIDTH] = cq[i][0].data;
               any = 1;
            end else begin
               reqValid[i] = 1'b0;
            end
         end
         if (any == 0) break;
         @(negedge clk);
         rdy = readyA;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) if (rdy[i] && cq[i].size() > 0) void'(cq[i].pop_front());
         n = n + 1;
         if (n > budget) begin
            timedOut = 1;
            for (int i = 0; i < NREQ; i++) cq[i].delete();
            break;
         end
      end
      reqValid = '0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; hold = 1'b0; reqValid = '1; reqOp = '0; reqData = '1;
      presetEn = 1'b1; presetVal = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (readyA !== '0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", readyA); end
      checks++; if ({incA, decA, loadA} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 000", {incA, decA, loadA}); end
      checks++; if (ldValA !== '0) begin errors++; $display("[TB] FAIL reset_ldval: got %h expected 00", ldValA); end
      checks++; if ({rspValidA, rspIdA, rspCountA, rspSatA} !== '0) begin errors++; $display("[TB] FAIL reset_rsp: valid %b id %0d count %h sat %b expected all 0", rspValidA, rspIdA, rspCountA, rspSatA); end
      @(posedge clk); #1;
      rst_n = 1'b0; reqValid = '0; presetEn = 1'b0;
      mdlLast = NREQ - 1; mdlCntA = 0; mdlCntB = 0;
      clearLogs();
   endtask

   task automatic test_single_up();
      int to;
      presetEn = 1'b1; presetVal = 8'h05;
      @(posedge clk); #1;
      presetEn = 1'b0; mdlCntA = 5; mdlCntB = 5;
      clearLogs();
      cq[0].push_back(mkCmd(OP_UP, 8'h00));
      modelPlan();
      driveAll(20, to);
      checks++; if (to !== 0) begin errors++; $display("[TB] FAIL single_timeout: got %0d expected 0", to); end
      checks++; if (gq.size() !== 1 || sqA.size() !== 1 || rqA.size() !== 1) begin errors++; $display("[TB] FAIL single_counts: grants %0d strobes %0d rsps %0d expected 1 1 1", gq.size(), sqA.size(), rqA.size()); end
      if (gq.size() == 1 && sqA.size() == 1 && rqA.size() == 1) begin
         checks++; if (gq[0].id !== 0) begin errors++; $display("[TB] FAIL single_grant_id: got %0d expected 0", gq[0].id); end
         checks++; if (sqA[0].kind !== 0 || sqA[0].cyc !== gq[0].cyc + 1) begin errors++; $display("[TB] FAIL single_inc: kind %0d at +%0d expected kind 0 at +1", sqA[0].kind, sqA[0].cyc - gq[0].cyc); end
         checks++; if (rqA[0].cyc !== gq[0].cyc + 2) begin errors++; $display("[TB] FAIL single_rsp_latency: got +%0d expected +2", rqA[0].cyc - gq[0].cyc); end
         checks++; if (rqA[0].id !== 0 || rqA[0].count !== 8'h06) begin errors++; $display("[TB] FAIL single_rsp: id %0d count %h expected id 0 count 06", rqA[0].id, rqA[0].count); end
      end
   endtask

   task automatic test_round_robin();
      int to;
      clearLogs();
      for (int i = 0; i < NREQ; i++) begin
         cq[i].push_back(mkCmd(OP_UP, 8'h00));
         cq[i].push_back(mkCmd(OP_UP, 8'h00));
      end
      modelPlan();
      driveAll(60, to);
      checks++; if (to !== 0) begin errors++; $display("[TB] FAIL rr_timeout: got %0d expected 0", to); end
      checks++; if (gq.size() !== eq.size() || rqA.size() !== eq.size()) begin errors++; $display("[TB] FAIL rr_counts: grants %0d rsps %0d expected %0d", gq.size(), rqA.size(), eq.size()); end
      for (int k = 0; k < eq.size() && k < gq.size() && k < rqA.size(); k++) begin
         checks++; if (gq[k].id !== eq[k].id) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", k, gq[k].id, eq[k].id); end
         if (k > 0) begin
            checks++; if (gq[k].cyc - gq[k-1].cyc !== 3) begin errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected 3", k, gq[k].cyc - gq[k-1].cyc); end
         end
         checks++; if (rqA[k].id !== eq[k].id || rqA[k].count !== eq[k].cntA) begin errors++; $display("[TB] FAIL rr_rsp[%0d]: id %0d count %0d expected id %0d count %0d", k, rqA[k].id, rqA[k].count, eq[k].id, eq[k].cntA); end
      end
      checks++; if (badReady !== 0) begin errors++; $display("[TB] FAIL rr_ready_onehot: got %0d bad cycles expected 0", badReady); end
   endtask

   task automatic test_saturation();
      int to;
      int expA[4] = '{255, 0, 0, 255};
      int expB[4] = '{255, 255, 0, 0};
      int satB[4] = '{0, 1, 0, 1};
      int kindA[4] = '{2, 0, 2, 1};
      clearLogs();
      cq[0].push_back(mkCmd(OP_LOAD, 8'hFF));
      cq[0].push_back(mkCmd(OP_UP, 8'h00));
      cq[0].push_back(mkCmd(OP_CLEAR, 8'h00));
      cq[0].push_back(mkCmd(OP_DOWN, 8'h00));
      modelPlan();
      driveAll(40, to);
      checks++; if (to !== 0) begin errors++; $display("[TB] FAIL sat_timeout: got %0d expected 0", to); end
      checks++; if (rqA.size() !== 4 || rqB.size() !== 4 || sqA.size() !== 4 || sqB.size() !== 2) begin errors++; $display("[TB] FAIL sat_counts: rspA %0d rspB %0d stbA %0d stbB %0d expected 4 4 4 2", rqA.size(), rqB.size(), sqA.size(), sqB.size()); end
      if (rqA.size() == 4 && rqB.size() == 4 && sqA.size() == 4 && sqB.size() == 2) begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (rqA[k].count !== expA[k] || rqA[k].sat !== 0) begin errors++; $display("[TB] FAIL sat_wrap_rsp[%0d]: count %0d sat %0d expected %0d 0", k, rqA[k].count, rqA[k].sat, expA[k]); end
            checks++; if (rqB[k].count !== expB[k] || rqB[k].sat !== satB[k]) begin errors++; $display("[TB] FAIL sat_sat_rsp[%0d]: count %0d sat %0d expected %0d %0d", k, rqB[k].count, rqB[k].sat, expB[k], satB[k]); end
            checks++; if (sqA[k].kind !== kindA[k]) begin errors++; $display("[TB] FAIL sat_wrap_strobe[%0d]: kind %0d expected %0d", k, sqA[k].kind, kindA[k]); end
         end
         checks++; if (sqB[0].val !== 255 || sqB[1].val !== 0 || sqB[0].kind !== 2 || sqB[1].kind !== 2) begin errors++; $display("[TB] FAIL sat_sat_strobes: vals %0d %0d expected loads of 255 0", sqB[0].val, sqB[1].val); end
      end
   endtask

   task automatic test_load_clear();
      int to;
      clearLogs();
      cq[2].push_back(mkCmd(OP_LOAD, 8'hA5));
      cq[2].push_back(mkCmd(OP_CLEAR, 8'h3C));
      modelPlan();
      driveAll(30, to);
      checks++; if (to !== 0) begin errors++; $display("[TB] FAIL ldclr_timeout: got %0d expected 0", to); end
      checks++; if (sqA.size() !== 2 || rqA.size() !== 2) begin errors++; $display("[TB] FAIL ldclr_counts: strobes %0d rsps %0d expected 2 2", sqA.size(), rqA.size()); end
      if (sqA.size() == 2 && rqA.size() == 2) begin
         checks++; if (sqA[0].kind !== 2 || sqA[0].val !== 8'hA5) begin errors++; $display("[TB] FAIL ldclr_load: kind %0d val %h expected 2 a5", sqA[0].kind, sqA[0].val); end
         checks++; if (sqA[1].kind !== 2 || sqA[1].val !== 0) begin errors++; $display("[TB] FAIL ldclr_clear: kind %0d val %h expected 2 00", sqA[1].kind, sqA[1].val); end
         checks++; if (rqA[0].count !== 8'hA5 || rqA[1].count !== 0 || rqA[0].id !== 2 || rqA[1].id !== 2) begin errors++; $display("[TB] FAIL ldclr_rsp: counts %h %h ids %0d %0d expected a5 00 ids 2 2", rqA[0].count, rqA[1].count, rqA[0].id, rqA[1].id); end
      end
   endtask

   task automatic test_hold();
      clearLogs();
      hold = 1'b1; reqValid = 4'b0010; reqOp = '0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (gq.size() !== 0 || sqA.size() !== 0 || rqA.size() !== 0) begin errors++; $display("[TB] FAIL hold_idle: grants %0d strobes %0d rsps %0d expected 0 0 0", gq.size(), sqA.size(), rqA.size()); end
      cq[1].push_back(mkCmd(OP_UP, 8'h00));
      modelPlan();
      cq[1].delete();
      hold = 1'b0;
      @(negedge clk);
      checks++; if (readyA !== 4'b0010) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 0010", readyA); end
      @(posedge clk); #1;
      hold = 1'b1; reqValid = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sqA.size() !== 1 || rqA.size() !== 1) begin errors++; $display("[TB] FAIL hold_exec_completes: strobes %0d rsps %0d expected 1 1", sqA.size(), rqA.size()); end
      if (rqA.size() == 1 && eq.size() == 1) begin
         checks++; if (rqA[0].id !== 1 || rqA[0].count !== eq[0].cntA) begin errors++; $display("[TB] FAIL hold_rsp: id %0d count %0d expected 1 %0d", rqA[0].id, rqA[0].count, eq[0].cntA); end
      end
      hold = 1'b0;
   endtask

   task automatic test_reset_mid();
      int to;
      clearLogs();
      reqValid = 4'b0001; reqOp = '0;
      @(negedge clk);
      checks++; if (readyA !== 4'b0001) begin errors++; $display("[TB] FAIL rstmid_grant: got %b expected 0001", readyA); end
      @(posedge clk); #1;
      rst_n = 1'b1; reqValid = 4'b1001;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gq.size() !== 1 || sqA.size() !== 0 || rqA.size() !== 0 || sqB.size() !== 0 || rqB.size() !== 0) begin errors++; $display("[TB] FAIL rstmid_abort: grants %0d strobes %0d rsps %0d expected 1 0 0", gq.size(), sqA.size(), rqA.size()); end
      rst_n = 1'b0; reqValid = '0;
      mdlLast = NREQ - 1;
      clearLogs();
      cq[0].push_back(mkCmd(OP_UP, 8'h00));
      cq[3].push_back(mkCmd(OP_UP, 8'h00));
      modelPlan();
      driveAll(30, to);
      checks++; if (to !== 0 || gq.size() !== 2 || rqA.size() !== 2) begin errors++; $display("[TB] FAIL rstmid_after: timeout %0d grants %0d rsps %0d expected 0 2 2", to, gq.size(), rqA.size()); end
      if (gq.size() == 2 && rqA.size() == 2) begin
         checks++; if (gq[0].id !== 0 || gq[1].id !== 3) begin errors++; $display("[TB] FAIL rstmid_order: got %0d,%0d expected 0,3", gq[0].id, gq[1].id); end
         checks++; if (rqA[1].count !== eq[1].cntA) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected %0d", rqA[1].count, eq[1].cntA); end
      end
   endtask

   task automatic test_random();
      int to;
      int n;
      logic [WIDTH-1:0] d;
      for (int round = 0; round < 5; round++) begin
         clearLogs();
         for (int i = 0; i < NREQ; i++) begin
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) begin
               case ($urandom_range(0, 3))
                  0:       d = 8'hFF;
                  1:       d = 8'h00;
                  default: d = WIDTH'($urandom_range(0, MAXV));
               endcase
               cq[i].push_back(mkCmd(2'($urandom_range(0, 3)), d));
            end
         end
         modelPlan();
         driveAll(200, to);
         checks++; if (to !== 0) begin errors++; $display("[TB] FAIL rand%0d_timeout: got %0d expected 0", round, to); end
         checks++; if (rqA.size() !== eq.size() || rqB.size() !== eq.size() || gq.size() !== eq.size()) begin errors++; $display("[TB] FAIL rand%0d_counts: grants %0d rspA %0d rspB %0d expected %0d", round, gq.size(), rqA.size(), rqB.size(), eq.size()); end
         for (int k = 0; k < eq.size() && k < rqA.size() && k < rqB.size(); k++) begin
            checks++; if (rqA[k].id !== eq[k].id || rqA[k].count !== eq[k].cntA) begin errors++; $display("[TB] FAIL rand%0d_wrap[%0d]: id %0d count %0d expected %0d %0d", round, k, rqA[k].id, rqA[k].count, eq[k].id, eq[k].cntA); end
            checks++; if (rqB[k].id !== eq[k].id || rqB[k].count !== eq[k].cntB || rqB[k].sat !== eq[k].satB) begin errors++; $display("[TB] FAIL rand%0d_sat[%0d]: id %0d count %0d sat %0d expected %0d %0d %0d", round, k, rqB[k].id, rqB[k].count, rqB[k].sat, eq[k].id, eq[k].cntB, eq[k].satB); end
         end
      end
      checks++; if (badReady !== 0) begin errors++; $display("[TB] FAIL ready_protocol: got %0d bad cycles expected 0", badReady); end
      checks++; if (badStrobe !== 0) begin errors++; $display("[TB] FAIL strobe_protocol: got %0d bad cycles expected 0", badStrobe); end
      checks++; if (badRsp !== 0) begin errors++; $display("[TB] FAIL rsp_protocol: got %0d bad cycles expected 0", badRsp); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_single_up();
      test_round_robin();
      test_saturation();
      test_load_clear();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
